// File: rtl/key_ctrl.sv
// key_ctrl: player control stage between the key scanner and the music sequencer.
// Tracks the IDLE/PLAY/PAUSE state and the selected song index, and issues a
// one-cycle restart strobe to the sequencer. A pause that lasts PAUSE_TMO cycles
// falls back to IDLE.
//
// Optional feature macro: AUTO_NEXT_EN
//   defined   : song_done in PLAY advances to the next song and restarts it
//   undefined : song_done in PLAY returns to IDLE
//
//   state | meaning
//   IDLE  | stopped, sequencer held, index may still be changed
//   PLAY  | sequencer advancing notes (play_en high)
//   PAUSE | sequencer frozen, timeout counter running while no key pressed
module key_ctrl #(
  parameter int SONG_NUM  = 4,
  parameter int SW        = 2,
  parameter int PAUSE_TMO = 250_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    key_evt,
  input  logic          song_done,
  output logic [SW-1:0] song_idx,
  output logic          play_en,
  output logic          song_start,
  output logic [1:0]    st
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam int            CW       = 28;
  localparam logic [CW-1:0] TMO_LAST = CW'(PAUSE_TMO - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(SONG_NUM - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] idx_nxt, idx_inc, idx_dec;
  logic          restart;
  logic          play_en_nxt, start_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Wrapping neighbours of the current index, kept inside 0..SONG_NUM-1
  assign idx_inc = (song_idx == IDX_LAST) ? '0 : song_idx + SW'(1);
  assign idx_dec = (song_idx == '0) ? IDX_LAST : song_idx - SW'(1);

  // State register: all outputs are registered, reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      song_idx   <= '0;
      play_en    <= 1'b0;
      song_start <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      song_idx   <= idx_nxt;
      play_en    <= play_en_nxt;
      song_start <= start_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Next-state logic: keys by priority stop > play/pause > next > prev, then
  // song_done (only with no key), then pause timeout
  always_comb begin
    state_nxt = state;
    idx_nxt   = song_idx;
    restart   = 1'b0;
    if (key_evt[3]) begin
      state_nxt = IDLE;
    end else if (key_evt[0]) begin
      case (state)
        IDLE:    begin state_nxt = PLAY; restart = 1'b1; end
        PLAY:    state_nxt = PAUSE;
        PAUSE:   state_nxt = PLAY;
        default: state_nxt = IDLE;
      endcase
    end else if (key_evt[1] || key_evt[2]) begin
      idx_nxt = key_evt[1] ? idx_inc : idx_dec;
      if (state != IDLE) begin
        state_nxt = PLAY;
        restart   = 1'b1;
      end
    end else if (state == PLAY && song_done) begin
`ifdef AUTO_NEXT_EN
      idx_nxt = idx_inc;
      restart = 1'b1;
`else
      state_nxt = IDLE;
`endif
    end else if (state == PAUSE && cnt == TMO_LAST) begin
      state_nxt = IDLE;
    end
  end

  // Output logic: next values for the registered outputs and the pause counter
  always_comb begin
    play_en_nxt = (state_nxt == PLAY);
    start_nxt   = restart;
    cnt_nxt     = '0;
    if (state == PAUSE && state_nxt == PAUSE && key_evt == 4'b0000)
      cnt_nxt = cnt + CW'(1);
  end

  assign st = state;

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl with SONG_NUM=4, PAUSE_TMO=100.
// A behavioural player model predicts each cycle's outputs into a queue;
// the entries are popped and compared after the clock edge.
module tb_key_ctrl;

  localparam int NS  = 4;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_evt = '0;
  logic       song_done = 1'b0;
  logic [1:0] song_idx;
  logic       play_en, song_start;
  logic [1:0] st;

  key_ctrl #(.SONG_NUM(NS), .SW(2), .PAUSE_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .key_evt(key_evt), .song_done(song_done),
    .song_idx(song_idx), .play_en(play_en), .song_start(song_start), .st(st)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] idx;
    logic       pe;
    logic       ss;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_st = 0, m_idx = 0, m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge
  task automatic step(input logic [3:0] k, input logic d);
    int   ns, ni, nc;
    bit   s;
    exp_t e, g;
    @(negedge clk);
    key_evt = k;
    song_done = d;
    ns = m_st; ni = m_idx; s = 0;
    if (k[3]) ns = 0;
    else if (k[0]) begin
      if (m_st == 0) begin ns = 1; s = 1; end
      else if (m_st == 1) ns = 2;
      else ns = 1;
    end else if (k[1] || k[2]) begin
      ni = k[1] ? (m_idx + 1) % NS : (m_idx + NS - 1) % NS;
      if (m_st != 0) begin ns = 1; s = 1; end
    end else if (m_st == 1 && d) begin
`ifdef AUTO_NEXT_EN
      ni = (m_idx + 1) % NS; s = 1;
`else
      ns = 0;
`endif
    end else if (m_st == 2 && m_cnt == TMO - 1) ns = 0;
    nc = (m_st == 2 && ns == 2 && k == 0) ? m_cnt + 1 : 0;
    m_st = ns; m_idx = ni; m_cnt = nc;
    e.st = 2'(ns); e.idx = 2'(ni); e.pe = (ns == 1); e.ss = s;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("st", st, g.st);
    chk("song_idx", song_idx, g.idx);
    chk("play_en", play_en, g.pe);
    chk("song_start", song_start, g.ss);
  endtask

  initial begin
    #12;
    chk("rst_st", st, 0);
    chk("rst_idx", song_idx, 0);
    chk("rst_play_en", play_en, 0);
    chk("rst_start", song_start, 0);
    @(negedge clk);
    rst = 1'b0;

    // Play from reset, strobe lasts one cycle
    step(4'b0001, 0);
    step(4'b0000, 0);
    // Wrap on next/prev at index boundary
    step(4'b0100, 0);
    chk("prev_wrap_idx", song_idx, 3);
    step(4'b0010, 0);
    chk("next_wrap_idx", song_idx, 0);
    step(4'b0100, 0);
    // All keys at once: stop wins
    step(4'b1111, 0);
    chk("stop_all_st", st, 0);
    chk("stop_all_idx", song_idx, 3);

    // Pause timeout
    step(4'b0001, 0);
    step(4'b0001, 0);
    for (int i = 0; i < TMO - 1; i++) step(4'b0000, 0);
    chk("tmo_before", st, 2);
    step(4'b0000, 0);
    chk("tmo_idle", st, 0);

    // Timeout cancelled by a next press mid-pause
    step(4'b0001, 0);
    step(4'b0001, 0);
    for (int i = 0; i < 49; i++) step(4'b0000, 0);
    step(4'b0010, 0);
    chk("cancel_start", song_start, 1);
    for (int i = 0; i < TMO + 10; i++) step(4'b0000, 0);
    chk("cancel_play", st, 1);

    // Re-pause after partial pause: counter must restart from zero
    step(4'b0001, 0);
    for (int i = 0; i < 60; i++) step(4'b0000, 0);
    step(4'b0001, 0);
    step(4'b0001, 0);
    for (int i = 0; i < 60; i++) step(4'b0000, 0);
    chk("repause_st", st, 2);
    step(4'b0001, 0);

    // song_done at index 1 in PLAY
    while (m_idx != 1) step(4'b0010, 0);
    step(4'b0000, 1);
`ifdef AUTO_NEXT_EN
    chk("done_auto_idx", song_idx, 2);
    chk("done_auto_st", st, 1);
`else
    chk("done_idle_st", st, 0);
    step(4'b0001, 0);
`endif
    step(4'b0001, 1);
    chk("done_with_key_st", st, 2);
    step(4'b0000, 1);

    // Index changes in IDLE, song_done ignored in IDLE
    step(4'b1000, 0);
    step(4'b0010, 0);
    step(4'b0100, 0);
    step(4'b0100, 0);
    step(4'b0100, 0);
    step(4'b0000, 1);

    // Random traffic, sparse keys, back-to-back allowed
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           1'($urandom_range(0, 5) == 0));

    // Async reset three cycles into a song
    step(4'b1000, 0);
    step(4'b0001, 0);
    step(4'b0000, 0);
    step(4'b0000, 0);
    step(4'b0000, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_st", st, 0);
    chk("arst_idx", song_idx, 0);
    chk("arst_play_en", play_en, 0);
    chk("arst_start", song_start, 0);
    m_st = 0; m_idx = 0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    step(4'b0001, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_ctrl.md
# key_ctrl

Player control stage that sits directly downstream of the debounced column-key scanner and upstream of the music sequencer. It consumes the scanner's one-cycle key-press flags and maintains the play/pause/stop state machine and the selected song index. It issues a one-cycle restart strobe to the sequencer and takes a song-finished pulse back from it. A pause that lasts too long falls back to idle.

## Interface
- SONG_NUM, 4, number of songs; legal range 2..16.
- SW, 2, width of song index; must satisfy 2^SW >= SONG_NUM.
- PAUSE_TMO, 250_000_000, pause timeout in clk cycles (10 s at 25 MHz); 28-bit counter.
- clk  in  1  system clock, 25 MHz.
- rst  in  1  asynchronous, active-high reset.
- key_evt  in  4  debounced press flags from scanner, 1-cycle pulses, active high: [0] play/pause, [1] next, [2] prev, [3] stop.
- song_done  in  1  1-cycle pulse from sequencer when current song ends.
- song_idx  out  SW  selected song, registered.
- play_en  out  1  high while in PLAY; sequencer advances notes only when high.
- song_start  out  1  1-cycle strobe: sequencer reloads song_idx from its first note.
- st  out  2  state code: IDLE=00, PLAY=01, PAUSE=10; 11 never produced.

## Operation
- Reset values: st=IDLE, song_idx=0, play_en=0, song_start=0, pause counter=0.
- Key priority when several key_evt bits are high in one cycle: stop > play/pause > next > prev. Only the highest-priority key is acted on; the others are discarded.
- Stop (bit 3): any state -> IDLE. song_idx is unchanged. No song_start.
- Play/pause (bit 0): IDLE -> PLAY with song_start. PLAY -> PAUSE. PAUSE -> PLAY without song_start (resume).
- Next (bit 1): song_idx = (song_idx == SONG_NUM-1) ? 0 : song_idx+1. From PLAY or PAUSE, go to PLAY with song_start. In IDLE, update the index only and stay in IDLE.
- Prev (bit 2): song_idx = (song_idx == 0) ? SONG_NUM-1 : song_idx-1. State handling is identical to next.
- song_done is honoured only in PLAY, and only when key_evt == 0 in the same cycle; a key event wins and song_done is dropped. Outside PLAY, song_done is ignored. Its effect depends on the Configuration section.
- Pause timeout:
  - The counter increments each cycle while st == PAUSE and key_evt == 0.
  - When the counter reaches PAUSE_TMO-1, the next edge sets st=IDLE and clears the counter.
  - The counter clears on any transition out of PAUSE.
  - The counter clears on any key_evt in PAUSE, including ignored lower-priority bits.
- Index arithmetic is modulo SONG_NUM. song_idx never holds a value >= SONG_NUM.

## Timing
- Every output is a registered function of the inputs. An event sampled at edge N is visible on outputs immediately after edge N (1-cycle latency).
- song_start is high for exactly one cycle, in the same cycle in which the new song_idx and play_en=1 first appear.
- play_en == (st == PLAY) at all times. It is registered, not decoded combinationally downstream.
- Back-to-back key_evt pulses on consecutive cycles are each processed. There is no lockout.
- rst asserted mid-song: all outputs return to reset values asynchronously. song_start is never left high.

## Configuration
- AUTO_NEXT_EN defined: song_done in PLAY advances song_idx as for next (with wrap), stays in PLAY, and pulses song_start.
- AUTO_NEXT_EN undefined: song_done in PLAY -> IDLE. song_idx is unchanged and no song_start is issued.

## Test plan
Bench parameters: SONG_NUM=4, PAUSE_TMO=100.
- Reset, then key_evt=0001 -> next cycle st=01, play_en=1, song_start=1 for exactly 1 cycle, song_idx=0.
- In PLAY at song_idx=3, key_evt=0010 -> song_idx=0, song_start pulse. Then key_evt=0100 -> song_idx=3, song_start pulse.
- In PLAY, key_evt=1111 -> st=00, play_en=0, song_idx unchanged, no song_start.
- In PLAY, key_evt=0001 -> st=10. Hold key_evt=0 for 100 cycles -> st=00 on the 100th cycle. Repeat with a 0010 pulse at cycle 50 -> st=01 with song_start, and the timeout is cancelled.
- song_done at song_idx=1 in PLAY:
  - AUTO_NEXT_EN: song_idx=2, song_start pulse, st=01.
  - Without AUTO_NEXT_EN: st=00.
  - With song_done and key_evt=0001 in the same cycle: st=10, song_done ignored.
- Assert rst 3 cycles after song_start in PLAY -> all outputs at reset values before the next clk edge.
